// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the
// shared binary-to-BCD converter.
package bcd_pkg;

  localparam int SAT_MAX  = 9999;
  localparam int BCD_W    = 16;
  localparam int DD_STEPS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/bcd_dd_core.sv
// Iterative double-dabble datapath: one add-3 and
// shift step per cycle over a 16-bit binary value.
module bcd_dd_core
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] din,
  input  logic             step,
  output logic [BCD_W-1:0] bcd
);

  logic [BCD_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;

  // Add 3 to every digit that would overflow past 9 after the shift
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Load clears the digits; each step shifts {bcd,bin} left by one
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else if (load) begin
      bin_q <= din;
      bcd_q <= '0;
    end else if (step) begin
      {bcd_q, bin_q} <= {adj[BCD_W-2:0], bin_q, 1'b0};
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin front end sharing one double-dabble
// converter; returns one tagged BCD result per grant.
module bcd_conv_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int BIN_W   = 16,
  parameter  int SAT_MAX = bcd_pkg::SAT_MAX,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*BIN_W-1:0] bin,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               done,
  output logic [ID_W-1:0]    done_id,
  output logic [15:0]        bcd
);

  import bcd_pkg::*;

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   win_q;
  logic [3:0]        cnt_q;
  logic [N_REQ-1:0]  gnt_q;
  logic              busy_q;
  logic              done_q;
  logic [ID_W-1:0]   done_id_q;
  logic [BCD_W-1:0]  bcd_q;

  logic [ID_W-1:0]   win_d;
  logic [ID_W-1:0]   ptr_d;
  logic [ID_W:0]     idx;
  logic              found;
  logic [BIN_W-1:0]  sel_bin;
  logic [BIN_W-1:0]  sat_bin;
  logic [BCD_W-1:0]  din;
  logic [BCD_W-1:0]  core_bcd;
  logic              load;
  logic              step;

  // First set request at or above the pointer, wrapping at N_REQ
  always_comb begin
    win_d = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_REQ)) begin
        idx = idx - (ID_W+1)'(N_REQ);
      end
      if (!found && req[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win_d = idx[ID_W-1:0];
      end
    end
  end

  assign ptr_d = (win_d == ID_W'(N_REQ-1)) ?
                 '0 : win_d + ID_W'(1);

  assign sel_bin = bin[win_d*BIN_W +: BIN_W];
  assign sat_bin = (sel_bin > BIN_W'(SAT_MAX)) ?
                   BIN_W'(SAT_MAX) : sel_bin;
  assign din     = BCD_W'(sat_bin);

  assign load = (state_q == IDLE) && !busy_q && (|req);
  assign step = (state_q == SHIFT);

  bcd_dd_core u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (din),
    .step (step),
    .bcd  (core_bcd)
  );

  // Control FSM; busy drops one cycle after done, which
  // keeps the grant-to-grant spacing at 19 cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      bcd_q     <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (|req) begin
            gnt_q   <= N_REQ'(1) << win_d;
            busy_q  <= 1'b1;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(DD_STEPS-1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q    <= 1'b1;
          done_id_q <= win_q;
          bcd_q     <= core_bcd;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign bcd     = bcd_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed
// vectors plus random traffic against a reference model.
module tb_bcd_conv_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] bin = '0;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           done;
  logic [1:0]     done_id;
  logic [15:0]    bcd;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(
    .N_REQ   (N),
    .BIN_W   (W),
    .SAT_MAX (9999)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .bin     (bin),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .bcd     (bcd)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(string nm, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  nm, act, exp);
  endtask

  // Decimal digits computed arithmetically from the clamped value
  function automatic logic [15:0] ref_bcd(int x);
    int v;
    v = (x > 9999) ? 9999 : x;
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int oh2i(logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  // ---------------- reference model / monitor ----------------
  typedef struct {
    int id;
    int b;
    int due;
  } exp_t;

  exp_t           q[$];
  exp_t           e;
  int             ncyc     = 0;
  int             ptr      = 0;
  int             free_c   = 0;
  int             busy_end = -1;
  int             eg;
  int             w;
  logic           p_rst = 1'b1;
  logic [N-1:0]   p_req = '0;
  logic [N*W-1:0] p_bin = '0;

  always @(negedge clk) begin
    ncyc++;
    if (p_rst) begin
      q.delete();
      ptr      = 0;
      free_c   = ncyc + 1;
      busy_end = -1;
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_bcd", bcd, 0);
    end else begin
      eg = 0;
      if (ncyc >= free_c && p_req != 0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && p_req[(ptr + k) % N]) w = (ptr + k) % N;
        eg       = 1 << w;
        ptr      = (w + 1) % N;
        free_c   = ncyc + 19;
        busy_end = ncyc + 17;
        e.id  = w;
        e.b   = ref_bcd(int'(p_bin[w*W +: W]));
        e.due = ncyc + 17;
        q.push_back(e);
      end
      chk("gnt", gnt, eg);
      chk("busy", busy, (ncyc <= busy_end) ? 1 : 0);
      if (q.size() > 0 && q[0].due == ncyc) begin
        chk("done", done, 1);
        chk("done_id", done_id, q[0].id);
        chk("bcd", bcd, q[0].b);
        void'(q.pop_front());
      end else begin
        chk("done", done, 0);
      end
    end
    p_rst = rst;
    p_req = req;
    p_bin = bin;
  end

  // ---------------- directed helpers ----------------
  int ng, nd;
  int g_ord[16];
  int g_cyc[16];
  int d_id[16];
  int d_bcd[16];
  int d_cyc[16];

  task automatic run_until(int want, int budget);
    logic [N-1:0] rel;
    ng = 0;
    nd = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      rel = gnt;
      if (gnt != 0 && ng < 16) begin
        g_ord[ng] = oh2i(gnt);
        g_cyc[ng] = c;
        ng++;
      end
      if (done && nd < 16) begin
        d_id[nd]  = int'(done_id);
        d_bcd[nd] = int'(bcd);
        d_cyc[nd] = c;
        nd++;
      end
      if (nd >= want) break;
      @(posedge clk);
      #1;
      req = req & ~rel;
    end
    chk("dones_seen", nd, want);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_bcd", bcd, 0);
    chk("reset_gnt", gnt, 0);
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 16'd0;
      1:       return 16'd9999;
      2:       return 16'd10000;
      3:       return 16'd65535;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  typedef struct {
    int          ch;
    int          val;
    logic [15:0] exp;
  } vec_t;

  vec_t         tv[9];
  logic [15:0]  e3[4];
  logic [N-1:0] gs;
  int           g, gnt1, done1, got0, dz;

  initial begin
    tv[0] = '{0, 42,    16'h0042};
    tv[1] = '{0, 0,     16'h0000};
    tv[2] = '{0, 9,     16'h0009};
    tv[3] = '{0, 9999,  16'h9999};
    tv[4] = '{0, 10000, 16'h9999};
    tv[5] = '{0, 65535, 16'h9999};
    tv[6] = '{1, 1234,  16'h1234};
    tv[7] = '{3, 500,   16'h0500};
    tv[8] = '{2, 8,     16'h0008};
    e3[0] = 16'h0001;
    e3[1] = 16'h0022;
    e3[2] = 16'h0333;
    e3[3] = 16'h4444;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single-channel conversions and boundaries
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      bin[tv[i].ch*W +: W] = 16'(tv[i].val);
      req = '0;
      req[tv[i].ch] = 1'b1;
      run_until(1, 40);
      if (ng > 0) chk("vec_gnt_id", g_ord[0], tv[i].ch);
      if (ng > 0 && nd > 0)
        chk("vec_latency", d_cyc[0] - g_cyc[0], 17);
      if (nd > 0) begin
        chk("vec_done_id", d_id[0], tv[i].ch);
        chk("vec_bcd", d_bcd[0], int'(tv[i].exp));
      end
    end

    // all four at once after reset: 0,1,2,3 at 19-cycle spacing
    do_reset();
    @(posedge clk);
    #1;
    bin = {16'd4444, 16'd333, 16'd22, 16'd1};
    req = 4'b1111;
    run_until(4, 120);
    for (int k = 0; k < 4; k++) begin
      if (k < ng) chk("rr_gnt_order", g_ord[k], k);
      if (k < nd) begin
        chk("rr_done_id", d_id[k], k);
        chk("rr_bcd", d_bcd[k], int'(e3[k]));
      end
      if (k > 0 && k < nd)
        chk("rr_spacing", d_cyc[k] - d_cyc[k-1], 19);
    end

    // pointer after ch2 is 3: ch3 beats ch1
    @(posedge clk);
    #1;
    bin[2*W +: W] = 16'd56;
    req = 4'b0100;
    run_until(1, 40);
    if (nd > 0) chk("ptr_first_id", d_id[0], 2);
    @(posedge clk);
    #1;
    bin[1*W +: W] = 16'd11;
    bin[3*W +: W] = 16'd33;
    req = 4'b1010;
    run_until(2, 80);
    if (ng > 1) begin
      chk("ptr_wrap_g0", g_ord[0], 3);
      chk("ptr_wrap_g1", g_ord[1], 1);
    end
    if (nd > 1) begin
      chk("ptr_wrap_bcd0", d_bcd[0], 16'h0033);
      chk("ptr_wrap_bcd1", d_bcd[1], 16'h0011);
    end

    // reset in mid-conversion aborts it
    @(posedge clk);
    #1;
    bin[0 +: W] = 16'd5000;
    req = 4'b0001;
    gs = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      gs = gnt;
      if (gs != 0) break;
    end
    chk("abort_gnt", gs, 4'b0001);
    @(posedge clk);
    #1 req = '0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd, 0);
    dz = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) dz++;
    end
    chk("abort_no_done", dz, 0);
    @(posedge clk);
    #1;
    bin[2*W +: W] = 16'd7;
    req = 4'b0100;
    run_until(1, 40);
    if (ng > 0) chk("post_rst_gnt", g_ord[0], 2);
    if (nd > 0) chk("post_rst_bcd", d_bcd[0], 16'h0007);

    // ch1 requests while busy and withdraws before done
    @(posedge clk);
    #1;
    bin[0 +: W] = 16'd77;
    bin[1*W +: W] = 16'd123;
    req = 4'b0001;
    g = -1;
    gnt1 = 0;
    done1 = 0;
    got0 = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (gnt[0] && g < 0) g = c;
      if (gnt[1]) gnt1++;
      if (done && done_id == 2'd1) done1++;
      if (done && done_id == 2'd0) begin
        got0++;
        chk("drop_bcd0", bcd, 16'h0077);
      end
      @(posedge clk);
      #1;
      if (g >= 0 && c == g) req[0] = 1'b0;
      if (g >= 0 && c == g + 3) req[1] = 1'b1;
      if (g >= 0 && c == g + 10) req[1] = 1'b0;
    end
    chk("drop_no_gnt1", gnt1, 0);
    chk("drop_no_done1", done1, 0);
    chk("drop_done0", got0, 1);

    // random traffic, checked by the monitor model
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      gs = gnt;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        if (gs[i]) begin
          if ($urandom_range(0, 7) != 0) req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
          else if ($urandom_range(0, 9) == 0)
            bin[i*W +: W] = rnd_val();
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          bin[i*W +: W] = rnd_val();
        end
      end
    end

    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0;
    repeat (25) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
